// File: rtl/cordic_quadrant_ctrl_pkg.sv
// Shared types and helpers for the CORDIC quadrant wrapper.
// Holds the FSM state type, the default widths and the saturating negate helper.
package cordic_pkg;

    localparam int ANG_W_DEF  = 16;
    localparam int DATA_W_DEF = 16;
    localparam logic [ANG_W_DEF-1:0] HALF_TURN = {1'b1, {(ANG_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_CORE,
        ST_OUT_VALID
    } state_t;

    // Operates on a sign-extended value of the given width.
    // The most negative code maps to the most positive one instead of wrapping.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] value,
                                                   input int width);
        logic signed [31:0] most_neg;
        most_neg = 32'sh8000_0000 >>> (32 - width);
        return (value == most_neg) ? ~most_neg : -value;
    endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a binary angle into [-pi/2, pi/2].
// Quadrants 1 and 2 are shifted by half a turn and flagged so the caller can negate the core result.
module cordic_quadrant_fold
    import cordic_pkg::*;
#(
    parameter int ANG_W = ANG_W_DEF
) (
    input  logic [ANG_W-1:0] i_angle,
    output logic [ANG_W-1:0] o_angle,
    output logic             o_flip
);

    localparam logic [ANG_W-1:0] HALF = {1'b1, {(ANG_W-1){1'b0}}};

    logic [1:0] w_q;

    assign w_q     = i_angle[ANG_W-1:ANG_W-2];
    assign o_flip  = w_q[1] ^ w_q[0];
    assign o_angle = o_flip ? (i_angle + HALF) : i_angle;

endmodule

// File: rtl/cordic_quadrant_ctrl.sv
// Request/response wrapper around the CORDIC core: angle folding, start/done sequencing,
// quadrant sign correction of cos/sin and a watchdog on the core.
module cordic_quadrant_ctrl
    import cordic_pkg::*;
#(
    parameter int ANG_W          = ANG_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ANG_W-1:0]         in_angle_i,
    output logic                     start_cordic_o,
    output logic [ANG_W-1:0]         angle_o,
    input  logic                     done_tick_cordic_i,
    input  logic signed [DATA_W-1:0] cos_i,
    input  logic signed [DATA_W-1:0] sin_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] out_cos_o,
    output logic signed [DATA_W-1:0] out_sin_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [ANG_W-1:0]           r_angle;
    logic                       r_flip;
    logic [WD_W-1:0]            r_wd;
    logic                       r_err;
    logic signed [DATA_W-1:0]   r_cos;
    logic signed [DATA_W-1:0]   r_sin;

    logic [ANG_W-1:0]           w_fold_angle;
    logic                       w_fold_flip;
    logic                       w_accept;
    logic                       w_capture;
    logic                       w_timeout;
    logic signed [DATA_W-1:0]   w_cos_corr;
    logic signed [DATA_W-1:0]   w_sin_corr;

    cordic_quadrant_fold #(
        .ANG_W (ANG_W)
    ) u_fold (
        .i_angle (in_angle_i),
        .o_angle (w_fold_angle),
        .o_flip  (w_fold_flip)
    );

    assign w_accept  = in_valid_i && (r_state == ST_IDLE);
    assign w_capture = done_tick_cordic_i && (r_state == ST_WAIT_CORE);
    assign w_timeout = !done_tick_cordic_i && (r_state == ST_WAIT_CORE) && (r_wd == WD_LAST);

    assign w_cos_corr = r_flip ? DATA_W'(sat_neg(32'(cos_i), DATA_W)) : cos_i;
    assign w_sin_corr = r_flip ? DATA_W'(sat_neg(32'(sin_i), DATA_W)) : sin_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        in_ready_o     = 1'b0;
        start_cordic_o = 1'b0;
        out_valid_o    = 1'b0;
        busy_o         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) w_next = ST_START;
            end
            ST_START: begin
                start_cordic_o = 1'b1;
                w_next         = ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
                if (done_tick_cordic_i) w_next = ST_OUT_VALID;
                else if (w_timeout)     w_next = ST_IDLE;
            end
            ST_OUT_VALID: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and watchdog: captures only in the states that own them, so stray ticks are inert.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_angle <= '0;
            r_flip  <= 1'b0;
            r_wd    <= '0;
            r_err   <= 1'b0;
            r_cos   <= '0;
            r_sin   <= '0;
        end else begin
            if (w_accept) begin
                r_angle <= w_fold_angle;
                r_flip  <= w_fold_flip;
            end
            if (r_state == ST_START) begin
                r_wd <= '0;
            end else if (r_state == ST_WAIT_CORE) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_capture) begin
                r_cos <= w_cos_corr;
                r_sin <= w_sin_corr;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign angle_o   = r_angle;
    assign out_cos_o = r_cos;
    assign out_sin_o = r_sin;
    assign err_o     = r_err;

endmodule

// File: doc/cordic_quadrant_ctrl.md
Name: cordic_quadrant_ctrl

Overview:
Front-end and back-end wrapper that sits directly upstream and downstream of the CORDIC control FSM and its datapath.
- Accepts angle requests over a valid/ready handshake.
- Folds each angle into the core's convergence range [-pi/2, pi/2].
- Issues the one-cycle start tick to the core and waits for its done tick.
- Applies quadrant sign correction to cos/sin and holds the result until it is consumed.
- Includes a watchdog that flags a core that never completes.

Parameters:
ANG_W, 16, angle width; binary-angle format, signed, 2^ANG_W counts = 2*pi, range [-pi, pi).
DATA_W, 16, cos/sin width; signed two's complement, as produced by the core.
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_CORE before abort; must be >= core latency + 1.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
in_valid_i  in  1  request valid.
in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
in_angle_i  in  ANG_W  requested angle.
start_cordic_o  out  1  one-cycle start tick to the core FSM.
angle_o  out  ANG_W  reduced angle to the core; stable from START until the return to IDLE.
done_tick_cordic_i  in  1  core completion tick; cos_i/sin_i are valid in the same cycle.
cos_i  in  DATA_W  core cosine.
sin_i  in  DATA_W  core sine.
out_valid_o  out  1  result valid.
out_ready_i  in  1  result consumed when out_valid_o && out_ready_i.
out_cos_o  out  DATA_W  corrected cosine; registered.
out_sin_o  out  DATA_W  corrected sine; registered.
busy_o  out  1  high in every state except IDLE.
err_o  out  1  sticky watchdog timeout flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - State returns to IDLE.
  - All outputs 0, except in_ready_o = 1 (IDLE).
  - angle_o, out_cos_o, out_sin_o, flip flag, watchdog counter and err_o are all 0.
- Reduction, registered on accept; q = in_angle_i[ANG_W-1:ANG_W-2]:
  - q = 00 or 11: angle_o = in_angle_i, flip = 0.
  - q = 01 or 10: angle_o = in_angle_i + 2^(ANG_W-1) (mod 2^ANG_W, i.e. subtract pi), flip = 1.
  - Boundaries: 0x4000 maps to 0xC000 with flip; 0xC000 passes unchanged; 0x8000 maps to 0x0000 with flip.
- Correction, registered on done tick:
  - flip = 0: out = core value.
  - flip = 1: out = -(core value), saturating; -(-2^(DATA_W-1)) = 2^(DATA_W-1)-1.
- FSM states and transitions:
  - IDLE: in_ready_o = 1. On accept: latch angle_o and flip, go to START.
  - START: start_cordic_o = 1 for exactly one cycle; clear watchdog; go to WAIT_CORE.
  - WAIT_CORE: watchdog increments each cycle.
    - On done_tick_cordic_i: register corrected results, go to OUT_VALID.
    - Else if watchdog == TIMEOUT_CYCLES-1: set err_o, go to IDLE, no result is produced.
  - OUT_VALID: out_valid_o = 1; out_cos_o/out_sin_o held stable. On out_ready_i: go to IDLE.
  - Illegal state encodings recover to IDLE.
- Latency:
  - Accept at cycle N; start_cordic_o at N+1.
  - Done tick at cycle D gives out_valid_o at D+1.
  - Earliest next accept is one cycle after the output handshake.
- in_ready_o is asserted only in IDLE; there is no overlap between requests.
- done_tick_cordic_i outside WAIT_CORE is ignored; no state change, no capture.
- Simultaneous in_valid_i and a stale done tick while in IDLE: the request is accepted and the tick is ignored.
- Reset mid-operation (any state) returns to IDLE on the next edge and drops any pending result. The core shares rst_i.
- err_o clears only on rst_i. Operation continues normally after a timeout.
- While out_valid_o is high and out_ready_i is low, all outputs are held.

Decomposition:
- Package cordic_pkg:
  - State enum for this block.
  - Default ANG_W/DATA_W constants.
  - Constant HALF_TURN = 2^(ANG_W-1).
  - Function sat_neg(value) for saturating negation.
- One natural sub-module, cordic_quadrant_fold: combinational q decode, angle fold and flip output. The FSM, correction and watchdog stay in the top module.

Test Plan:
- First quadrant: angle 0x2000; mock core returns cos 0x5A82, sin 0x5A82 -> angle_o 0x2000, outputs 0x5A82/0x5A82, start_cordic_o high for exactly 1 cycle.
- Second quadrant: angle 0x6000 -> angle_o 0xE000; mock returns cos 0x5A82, sin 0xA57E -> out_cos 0xA57E, out_sin 0x5A82.
- Boundaries:
  - 0x4000 -> angle_o 0xC000, flip.
  - 0xC000 -> 0xC000, no flip.
  - 0x8000 -> 0x0000; mock cos 0x7FFF, sin 0x0000 -> out 0x8001/0x0000.
  - Mock cos 0x8000 with flip -> out_cos 0x7FFF (saturation).
- Handshake backpressure: hold out_ready_i low for 10 cycles -> outputs stable, in_ready_o low; a spurious done tick in OUT_VALID is ignored; release -> IDLE the next cycle.
- Watchdog: TIMEOUT_CYCLES = 8, mock never ticks -> err_o rises 8 cycles after START, no out_valid_o; a following request completes normally and err_o stays 1.
- Reset mid-WAIT_CORE: assert rst_i for 1 cycle -> next edge IDLE, all outputs 0; a late done tick produces no output.
